// File: rtl/core_s2p_pkg.sv
// Shared types and helpers for the serial-to-parallel collector.
package core_s2p_pkg;

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_e;

   // Out-of-range requests (zero or larger than the array) mean "fill the whole array".
   function automatic int sat_target(input int word_count, input int length);
      if (word_count == 0 || word_count > length) begin
         return length;
      end
      return word_count;
   endfunction

endpackage

// File: rtl/core_s2p_slot.sv
// One word-wide storage slot: synchronous active-low reset, clear, then write enable.
module core_s2p_slot #(
   parameter int Bits = 8
) (
   input  logic            clk_i,
   input  logic            srst_ni,
   input  logic            we_i,
   input  logic            clr_i,
   input  logic [Bits-1:0] d_i,
   output logic [Bits-1:0] q_o
);

   always_ff @(posedge clk_i) begin
      if (!srst_ni) begin
         q_o <= '0;
      end else if (clr_i) begin
         q_o <= '0;
      end else if (we_i) begin
         q_o <= d_i;
      end
   end

endmodule

// File: rtl/core_serial_to_parallel_collect.sv
// Collects handshaked words into a Length-deep frame and holds it until drained.
// Optional sticky overflow_o output is enabled by defining CORE_S2P_OVERFLOW_FLAG_EN.
module core_serial_to_parallel_collect
   import core_s2p_pkg::*;
#(
   parameter int Bits   = 8,
   parameter int Length = 16
) (
   input  logic                        clk_i,
   input  logic                        srst_ni,
   input  logic                        en_i,
   input  logic [Bits-1:0]             data_i,
   input  logic                        valid_i,
   output logic                        ready_o,
   input  logic [$clog2(Length+1)-1:0] word_count_i,
   output logic [Bits-1:0]             store_o [Length],
   output logic [$clog2(Length+1)-1:0] count_o,
   output logic                        full_o,
   input  logic                        drain_i,
   input  logic                        assert_on_i
`ifdef CORE_S2P_OVERFLOW_FLAG_EN
   ,
   output logic                        overflow_o
`endif
);

   localparam int CW = $clog2(Length+1);

   state_e          state;
   state_e          state_next;
   logic [CW-1:0]   target;
   logic [CW-1:0]   tgt_eff;
   logic            accept;
   logic            clear;

   // The first accept of a frame uses the live request; later accepts use the latched one.
   assign tgt_eff = (count_o == '0) ? CW'(sat_target(int'(word_count_i), Length)) : target;
   assign accept  = valid_i && ready_o;
   assign clear   = (state == FULL) && drain_i;

   always_ff @(posedge clk_i) begin
      if (!srst_ni) begin
         state <= COLLECT;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      ready_o    = 1'b0;
      full_o     = 1'b0;
      case (state)
         COLLECT: begin
            ready_o = en_i;
            if (valid_i && en_i && (count_o + CW'(1)) == tgt_eff) begin
               state_next = FULL;
            end
         end
         FULL: begin
            full_o = 1'b1;
            if (drain_i) begin
               state_next = COLLECT;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!srst_ni) begin
         count_o <= '0;
         target  <= '0;
      end else if (clear) begin
         count_o <= '0;
      end else if (accept) begin
         count_o <= count_o + CW'(1);
         if (count_o == '0) begin
            target <= tgt_eff;
         end
      end
   end

   for (genvar g = 0; g < Length; g++) begin : g_slot
      core_s2p_slot #(
         .Bits (Bits)
      ) u_slot (
         .clk_i   (clk_i),
         .srst_ni (srst_ni),
         .we_i    (accept && (count_o == CW'(g))),
         .clr_i   (clear),
         .d_i     (data_i),
         .q_o     (store_o[g])
      );
   end

   always_ff @(posedge clk_i) begin
      if (srst_ni && accept && (count_o == '0) && assert_on_i) begin
         assert (word_count_i != '0 && int'(word_count_i) <= Length)
         else $warning("word_count_i=%0d out of range, using %0d", word_count_i, Length);
      end
   end

`ifdef CORE_S2P_OVERFLOW_FLAG_EN
   logic overflow_set;
   assign overflow_set = (state == FULL) && valid_i && !drain_i;

   always_ff @(posedge clk_i) begin
      if (!srst_ni) begin
         overflow_o <= 1'b0;
      end else if (overflow_set) begin
         overflow_o <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (srst_ni && overflow_set && assert_on_i) begin
         assert (overflow_o)
         else $warning("valid_i presented while frame held");
      end
   end
`endif

endmodule

// File: tb/tb_core_serial_to_parallel_collect.sv
// Scoreboard bench for core_serial_to_parallel_collect (Bits=8, Length=16).
module tb_core_serial_to_parallel_collect;

   localparam int Bits   = 8;
   localparam int Length = 16;
   localparam int CW     = $clog2(Length+1);

   logic            clk_i = 1'b0;
   logic            srst_ni;
   logic            en_i;
   logic [Bits-1:0] data_i;
   logic            valid_i;
   logic            ready_o;
   logic [CW-1:0]   word_count_i;
   logic [Bits-1:0] store_o [Length];
   logic [CW-1:0]   count_o;
   logic            full_o;
   logic            drain_i;
   logic            assert_on_i;
`ifdef CORE_S2P_OVERFLOW_FLAG_EN
   logic            overflow_o;
`endif

   int checks   = 0;
   int failures = 0;
   logic [Bits-1:0] exp_q [$];

   core_serial_to_parallel_collect #(
      .Bits   (Bits),
      .Length (Length)
   ) dut (
      .clk_i        (clk_i),
      .srst_ni      (srst_ni),
      .en_i         (en_i),
      .data_i       (data_i),
      .valid_i      (valid_i),
      .ready_o      (ready_o),
      .word_count_i (word_count_i),
      .store_o      (store_o),
      .count_o      (count_o),
      .full_o       (full_o),
      .drain_i      (drain_i),
      .assert_on_i  (assert_on_i)
`ifdef CORE_S2P_OVERFLOW_FLAG_EN
      ,
      .overflow_o   (overflow_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   // Present one word that must be accepted this cycle; it joins the expected frame.
   task automatic send_word(input logic [Bits-1:0] d, input logic [CW-1:0] wc);
      data_i       = d;
      word_count_i = wc;
      valid_i      = 1'b1;
      #1;
      check("ready_accept", 32'(ready_o), 32'd1);
      exp_q.push_back(d);
      cyc();
   endtask

   // Compare the whole array against the scoreboard; unused slots must be zero.
   task automatic check_frame(input string tag, input logic want_full);
      check({tag, "_full"}, 32'(full_o), 32'(want_full));
      check({tag, "_count"}, 32'(count_o), 32'(exp_q.size()));
      for (int i = 0; i < Length; i++) begin
         check($sformatf("%s_slot%0d", tag, i), 32'(store_o[i]),
               (i < exp_q.size()) ? 32'(exp_q[i]) : 32'd0);
      end
   endtask

   task automatic drain();
      valid_i = 1'b0;
      drain_i = 1'b1;
      cyc();
      drain_i = 1'b0;
      exp_q.delete();
      check_frame("drain", 1'b0);
   endtask

   initial begin
      srst_ni      = 1'b0;
      en_i         = 1'b1;
      data_i       = '0;
      valid_i      = 1'b0;
      word_count_i = '0;
      drain_i      = 1'b0;
      assert_on_i  = 1'b1;
      cyc();
      cyc();
      srst_ni = 1'b1;
      #1;
      check_frame("reset", 1'b0);
      check("reset_ready", 32'(ready_o), 32'd1);
`ifdef CORE_S2P_OVERFLOW_FLAG_EN
      check("reset_ovf", 32'(overflow_o), 32'd0);
`endif

      // Four-word frame with valid held high.
      for (int i = 0; i < 4; i++) begin
         send_word(8'hA1 + 8'(i), CW'(4));
         if (i < 3) check($sformatf("t1_notfull%0d", i), 32'(full_o), 32'd0);
      end
      check_frame("t1", 1'b1);
      check("t1_ready", 32'(ready_o), 32'd0);

      // Held frame ignores further valid words.
      data_i = 8'hEE;
      for (int i = 0; i < 3; i++) begin
         check($sformatf("t2_ready%0d", i), 32'(ready_o), 32'd0);
         cyc();
         check_frame($sformatf("t2_hold%0d", i), 1'b1);
`ifdef CORE_S2P_OVERFLOW_FLAG_EN
         check($sformatf("t2_ovf%0d", i), 32'(overflow_o), 32'd1);
`endif
      end

      // Drain together with a presented word: the word is not taken.
      data_i  = 8'h55;
      valid_i = 1'b1;
      drain_i = 1'b1;
      cyc();
      drain_i = 1'b0;
      exp_q.delete();
      check_frame("t3_drain", 1'b0);
      send_word(8'h55, CW'(2));
      check_frame("t3_first", 1'b0);
      send_word(8'h66, CW'(2));
      check_frame("t3_full", 1'b1);
      drain();

      // Out-of-range targets clamp to the full array.
      assert_on_i = 1'b0;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < Length; i++) begin
            send_word(8'(8'h10 * pass + i + 1), (pass == 0) ? CW'(0) : CW'(20));
            if (i == Length - 2) check($sformatf("t4_notfull%0d", pass), 32'(full_o), 32'd0);
         end
         valid_i = 1'b0;
         check_frame($sformatf("t4_full%0d", pass), 1'b1);
         drain();
      end
      assert_on_i = 1'b1;

      // Reset mid-frame.
      send_word(8'h77, CW'(4));
      send_word(8'h78, CW'(4));
      valid_i = 1'b0;
      srst_ni = 1'b0;
      cyc();
      srst_ni = 1'b1;
      exp_q.delete();
      #1;
      check_frame("t5_reset", 1'b0);
      check("t5_ready", 32'(ready_o), 32'd1);
`ifdef CORE_S2P_OVERFLOW_FLAG_EN
      check("t5_ovf", 32'(overflow_o), 32'd0);
`endif

      // Enable gaps and a mid-frame target change.
      send_word(8'h31, CW'(3));
      en_i    = 1'b0;
      data_i  = 8'h32;
      valid_i = 1'b1;
      for (int i = 0; i < 2; i++) begin
         #1;
         check($sformatf("t6_ready_off%0d", i), 32'(ready_o), 32'd0);
         cyc();
         check($sformatf("t6_count_off%0d", i), 32'(count_o), 32'd1);
      end
      en_i = 1'b1;
      send_word(8'h32, CW'(1));
      check_frame("t6_mid", 1'b0);
      send_word(8'h33, CW'(1));
      valid_i = 1'b0;
      check_frame("t6_full", 1'b1);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
